fir_mac_sequencer: RTL and testbench

//  Control sequencer for the time-multiplexed single-MAC FIR datapath.

---
 rtl/fir_mac_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
//   Control sequencer for a time-multiplexed single-MAC FIR datapath. It clears
//   the circular sample buffer after reset. It accepts one sample word per
//   handshake and writes that word into the buffer. It then steps the buffer and
//   the coefficient ROM through TAPS products on the MAC, waits out the MAC
//   pipeline and offers the result downstream. It drives only addresses and
//   strobes; no sample or coefficient data passes through it.
//
//   Handshakes: both sides use strict valid/ready. A transfer happens in any
//   cycle where valid and ready are both 1 at the rising clock edge.
//     input side : i_din_valid / o_ready (o_ready only in IDLE, gated by i_en)
//     output side: o_dout_valid / i_ready (o_dout_valid held until consumed;
//                  a consume needs i_en=1)
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_en               global enable (0 = stall, except during CLEAR)
//   i_din_valid        upstream has a sample word
//   o_ready            sequencer accepts a sample this cycle
//   o_wr_en            sample buffer write strobe
//   o_wr_zero          write zero instead of the input word (buffer clear)
//   ov_wr_addr         sample buffer write address
//   ov_smp_addr        sample buffer read address
//   ov_coef_addr       coefficient ROM read address
//   o_acc_en           MAC accepts a product this cycle
//   o_acc_clr          MAC loads instead of accumulating (first tap)
//   o_dout_valid       MAC result valid downstream
//   i_ready            downstream consumes the result
//   o_busy             1 in any state other than IDLE
//   ov_dbg_state       current FSM state encoding (debug)
module fir_mac_sequencer #(
  parameter int TAPS    = 16,
  parameter int MAC_LAT = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_din_valid,
  output logic                      o_ready,
  output logic                      o_wr_en,
  output logic                      o_wr_zero,
  output logic [$clog2(TAPS)-1:0]   ov_wr_addr,
  output logic [$clog2(TAPS)-1:0]   ov_smp_addr,
  output logic [$clog2(TAPS)-1:0]   ov_coef_addr,
  output logic                      o_acc_en,
  output logic                      o_acc_clr,
  output logic                      o_dout_valid,
  input  logic                      i_ready,
  output logic                      o_busy,
  output logic [2:0]                ov_dbg_state
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int DW     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] head, head_nx;   // next write slot
  logic [ADDR_W-1:0] k, k_nx;         // tap index / clear index
  logic [ADDR_W-1:0] smp_q, smp_nx;   // read address; loaded with the newest slot
  logic [ADDR_W-1:0] coef_q, coef_nx;
  logic [ADDR_W-1:0] wr_q, wr_nx;     // last write address, held outside CLEAR/IDLE
  logic [DW-1:0]     drn, drn_nx;     // MAC pipeline drain counter

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_CLEAR;
      head   <= '0;
      k      <= '0;
      smp_q  <= '0;
      coef_q <= '0;
      wr_q   <= '0;
      drn    <= '0;
    end else begin
      state  <= state_nx;
      head   <= head_nx;
      k      <= k_nx;
      smp_q  <= smp_nx;
      coef_q <= coef_nx;
      wr_q   <= wr_nx;
      drn    <= drn_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    head_nx   = head;
    k_nx      = k;
    smp_nx    = smp_q;
    coef_nx   = coef_q;
    wr_nx     = wr_q;
    drn_nx    = drn;
    o_ready   = 1'b0;
    o_wr_en   = 1'b0;
    o_wr_zero = 1'b0;
    o_acc_en  = 1'b0;
    o_acc_clr = 1'b0;

    case (state)
      S_CLEAR: begin
        // Held-off while reset is still asserted so the reset cycles show
        // only o_busy; the clear itself ignores i_en.
        if (!i_rst) begin
          o_wr_en   = 1'b1;
          o_wr_zero = 1'b1;
          wr_nx     = k;
          if (k == LAST) begin
            k_nx     = '0;
            state_nx = S_IDLE;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end

      S_IDLE: begin
        o_ready = i_en;
        if (i_en && i_din_valid) begin
          o_wr_en  = 1'b1;
          wr_nx    = head;
          // The slot just written is the newest sample: tap 0 reads it.
          smp_nx   = head;
          coef_nx  = '0;
          k_nx     = '0;
          head_nx  = (head == LAST) ? '0 : head + 1'b1;
          state_nx = S_MAC;
        end
      end

      S_MAC: begin
        if (i_en) begin
          o_acc_en  = 1'b1;
          o_acc_clr = (k == '0);
          if (k == LAST) begin
            k_nx     = '0;
            drn_nx   = '0;
            state_nx = (MAC_LAT == 0) ? S_HOLD : S_DRAIN;
          end else begin
            k_nx    = k + 1'b1;
            coef_nx = k + 1'b1;
            // Walk backwards through the circular buffer; explicit wrap so
            // TAPS need not be a power of two.
            smp_nx  = (smp_q == '0) ? LAST : smp_q - 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (i_en) begin
          if (drn == DW'(MAC_LAT - 1)) begin
            drn_nx   = '0;
            state_nx = S_HOLD;
          end else begin
            drn_nx = drn + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (i_en && i_ready) state_nx = S_IDLE;
      end

      default: state_nx = S_CLEAR;
    endcase
  end

  always_comb begin
    case (state)
      S_CLEAR: ov_wr_addr = k;
      S_IDLE:  ov_wr_addr = head;
      default: ov_wr_addr = wr_q;
    endcase
  end

  assign ov_smp_addr  = smp_q;
  assign ov_coef_addr = coef_q;
  assign o_dout_valid = (state == S_HOLD);
  assign o_busy       = (state != S_IDLE);
  assign ov_dbg_state = state;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
module tb_fir_mac_sequencer;
  localparam int TAPS    = 4;
  localparam int MAC_LAT = 2;
  localparam int AW      = $clog2(TAPS);

  // clock / reset
  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic          i_rst = 1'b1;
  logic          i_en = 1'b1;
  logic          i_din_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_ready, o_wr_en, o_wr_zero, o_acc_en, o_acc_clr;
  logic          o_dout_valid, o_busy;
  logic [AW-1:0] ov_wr_addr, ov_smp_addr, ov_coef_addr;
  logic [2:0]    ov_dbg_state;
  logic [7:0]    din_word = 8'd0;

  fir_mac_sequencer #(.TAPS(TAPS), .MAC_LAT(MAC_LAT)) dut (
    .i_clk        (tb_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din_valid  (i_din_valid),
    .o_ready      (o_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_zero    (o_wr_zero),
    .ov_wr_addr   (ov_wr_addr),
    .ov_smp_addr  (ov_smp_addr),
    .ov_coef_addr (ov_coef_addr),
    .o_acc_en     (o_acc_en),
    .o_acc_clr    (o_acc_clr),
    .o_dout_valid (o_dout_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .ov_dbg_state (ov_dbg_state)
  );

  // datapath models and scoreboard
  int          coef_rom [TAPS] = '{3, 5, 7, 11};
  int          buf_m [TAPS];
  int          hist [TAPS];
  int          acc_m = 0;
  int          y_m;
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          head_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Golden FIR on accepted words pushes the expectation; a MAC model driven by
  // the sequencer's addresses produces the observed result at each consume.
  always @(posedge tb_clk) begin
    if (i_rst) begin
      exp_q.delete();
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
    end else begin
      if (o_wr_en) buf_m[ov_wr_addr] = o_wr_zero ? 0 : int'(din_word);
      if (o_ready && i_din_valid) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(din_word);
        y_m = 0;
        for (int i = 0; i < TAPS; i++) y_m += coef_rom[i] * hist[i];
        exp_q.push_back(32'(y_m));
      end
      if (o_acc_en)
        acc_m = (o_acc_clr ? 0 : acc_m) + buf_m[ov_smp_addr] * coef_rom[ov_coef_addr];
      if (o_dout_valid && i_ready && i_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL unexpected_result observed=%0d expected=none", acc_m);
        end else begin
          chk("fir_result", 32'(acc_m), exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge tb_clk);
  endtask

  // Offers a word until accepted; returns at the start of the cycle after the
  // handshake with the slot the word was written to.
  task automatic send(input logic [7:0] w, output int nw);
    int n;
    n = 0;
    i_din_valid = 1'b1;
    din_word = w;
    settle();
    while (o_ready !== 1'b1 && n < 100) begin
      next_cycle();
      settle();
      n++;
    end
    if (n >= 100) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout observed=no_ready expected=ready");
    end
    chk("send_wr_en", o_wr_en, 1);
    chk("send_wr_zero", o_wr_zero, 0);
    chk("send_wr_addr", ov_wr_addr, head_b);
    nw = head_b;
    head_b = (head_b + 1) % TAPS;
    next_cycle();
    i_din_valid = 1'b0;
  endtask

  initial begin
    int nw;
    int n;

    // reset state
    next_cycle();
    next_cycle();
    settle();
    chk("rst_busy", o_busy, 1);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_acc_en", o_acc_en, 0);
    chk("rst_dout_valid", o_dout_valid, 0);
    next_cycle();
    i_rst = 1'b0;

    // buffer clear C0..C3, then IDLE at C4
    for (int c = 0; c < TAPS; c++) begin
      settle();
      chk("clr_wr_en", o_wr_en, 1);
      chk("clr_wr_zero", o_wr_zero, 1);
      chk("clr_wr_addr", ov_wr_addr, c);
      chk("clr_ready", o_ready, 0);
      next_cycle();
    end
    settle();
    chk("idle_ready", o_ready, 1);
    chk("idle_busy", o_busy, 0);
    next_cycle();

    // impulse at head 0: tap sequence and result latency
    send(8'd1, nw);
    for (int j = 0; j < TAPS; j++) begin
      settle();
      chk("mac_acc_en", o_acc_en, 1);
      chk("mac_acc_clr", o_acc_clr, (j == 0));
      chk("mac_coef_addr", ov_coef_addr, j);
      chk("mac_smp_addr", ov_smp_addr, (nw - j + TAPS) % TAPS);
      chk("mac_ready", o_ready, 0);
      next_cycle();
    end
    settle();
    chk("drain_acc_en", o_acc_en, 0);
    chk("drain_dout_t5", o_dout_valid, 0);
    next_cycle();
    settle();
    chk("drain_dout_t6", o_dout_valid, 0);
    next_cycle();

    // backpressure in HOLD, with a competing input word that must be ignored
    i_din_valid = 1'b1;
    din_word = 8'hAA;
    for (int b = 0; b < 10; b++) begin
      settle();
      chk("bp_dout_valid", o_dout_valid, 1);
      chk("bp_ready", o_ready, 0);
      chk("bp_wr_en", o_wr_en, 0);
      next_cycle();
    end
    i_din_valid = 1'b0;
    i_en = 1'b0;
    i_ready = 1'b1;
    settle();
    chk("stall_hold_dout", o_dout_valid, 1);
    chk("stall_hold_ready", o_ready, 0);
    next_cycle();
    i_en = 1'b1;
    settle();
    chk("consume_ignored_dout", o_dout_valid, 1);
    next_cycle();
    settle();
    chk("post_consume_dout", o_dout_valid, 0);
    chk("post_consume_ready", o_ready, 1);
    chk("post_consume_busy", o_busy, 0);
    next_cycle();

    // wrap: the fifth sample lands in slot 0
    for (int s = 0; s < 3; s++) send(8'd0, nw);
    send(8'd0, nw);
    for (int j = 0; j < TAPS; j++) begin
      settle();
      chk("wrap_smp_addr", ov_smp_addr, (0 - j + TAPS) % TAPS);
      next_cycle();
    end

    // random stream against the golden model
    for (int s = 0; s < 100; s++) send(8'($urandom_range(0, 255)), nw);

    // stall of three cycles at T+2
    send(8'd5, nw);
    settle();
    chk("st_acc_en_t1", o_acc_en, 1);
    chk("st_coef_t1", ov_coef_addr, 0);
    chk("st_smp_t1", ov_smp_addr, nw);
    next_cycle();
    i_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      settle();
      chk("st_acc_en_frozen", o_acc_en, 0);
      chk("st_acc_clr_frozen", o_acc_clr, 0);
      chk("st_coef_frozen", ov_coef_addr, 1);
      chk("st_smp_frozen", ov_smp_addr, (nw + TAPS - 1) % TAPS);
      next_cycle();
    end
    i_en = 1'b1;
    settle();
    chk("st_resume_acc_en", o_acc_en, 1);
    chk("st_resume_clr", o_acc_clr, 0);
    chk("st_resume_coef", ov_coef_addr, 1);
    for (int c = 6; c <= 10; c++) begin
      next_cycle();
      settle();
      chk("st_dout_timing", o_dout_valid, (c == 10));
    end
    next_cycle();
    settle();
    chk("st_after_dout", o_dout_valid, 0);
    chk("st_after_ready", o_ready, 1);
    next_cycle();

    // reset at T+3 abandons the sample in flight
    send(8'd7, nw);
    next_cycle();
    i_rst = 1'b1;
    settle();
    next_cycle();
    i_rst = 1'b0;
    head_b = 0;
    for (int c = 0; c < TAPS; c++) begin
      settle();
      chk("rr_acc_en", o_acc_en, 0);
      chk("rr_dout_valid", o_dout_valid, 0);
      chk("rr_ready", o_ready, 0);
      chk("rr_wr_zero", o_wr_zero, 1);
      chk("rr_wr_addr", ov_wr_addr, c);
      next_cycle();
    end
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("rr_no_result", o_dout_valid, 0);
      next_cycle();
    end
    send(8'd2, nw);

    // wait for every expected result to be consumed
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      next_cycle();
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
